// File: rtl/loop_lock_pkg.sv
// Shared definitions for the loop-lock tracker: call policy encodings and
// the modulo-n ring pointer step used by the loop stack.
package loop_lock_pkg;

  localparam int unsigned CALL_POLICY_FREEZE = 32'd0;
  localparam int unsigned CALL_POLICY_CLEAR  = 32'd1;

  localparam logic PTR_UP = 1'b1;
  localparam logic PTR_DN = 1'b0;

  // Step a ring pointer by one in either direction with explicit wrap so
  // that non-power-of-2 ring sizes work.
  function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                           input logic        dir,
                                           input int unsigned n);
    if (dir) begin
      return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
    end else begin
      return (ptr == 32'd0) ? n - 32'd1 : ptr - 32'd1;
    end
  endfunction

endpackage

// File: rtl/loop_range_cmp.sv
// Address-range comparator for one loop-stack entry: tells whether the
// decode PC lies inside the loop body and whether the taken branch is the
// loop's own closing branch.
module loop_range_cmp #(
  parameter int unsigned PC_W = 31
) (
  input  logic [PC_W:1] pc,
  input  logic [PC_W:1] tgt,
  input  logic [PC_W:1] first,
  input  logic [PC_W:1] last,
  output logic          in_range,
  output logic          match_pair
);

  assign in_range   = (first <= pc) && (pc <= last);
  assign match_pair = (tgt == first) && (pc == last);

endmodule

// File: rtl/loop_lock_tracker.sv
// Decode-stage loop tracker driving the I-cache lock. Nested backward-branch
// loops are kept on a circular stack; the cache is locked only while the PC
// is inside the innermost loop and that loop has repeated LOCK_THRESH times.
module loop_lock_tracker
  import loop_lock_pkg::*;
#(
  parameter int unsigned ENTRIES     = 4,
  parameter int unsigned PC_W        = 31,
  parameter int unsigned ITER_W      = 4,
  parameter int unsigned LOCK_THRESH = 2,
  parameter int unsigned CALL_CLEAR  = 1
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         inst_valid,
  input  logic                         is_call,
  input  logic                         is_ret,
  input  logic                         dec_takenbr,
  input  logic [PC_W:1]                dec_takenbr_target,
  input  logic [PC_W:1]                last_pc,
  input  logic                         lock_clr,
  output logic                         lock_cache,
  output logic                         lock_start,
  output logic [$clog2(ENTRIES+1)-1:0] depth
);

  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);
  localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CNT_W-1:0]  FULL = CNT_W'(ENTRIES);
  localparam logic [ITER_W-1:0] THR  = ITER_W'(LOCK_THRESH);

  typedef struct packed {
    logic [PC_W:1]     first;
    logic [PC_W:1]     last;
    logic [ITER_W-1:0] iter;
  } entry_t;

  entry_t            r_ring [ENTRIES];
  logic [PTR_W-1:0]  r_head;
  logic [CNT_W-1:0]  r_count;
  logic              r_frozen;
  logic              r_last_lock;

  entry_t            w_top;
  entry_t            w_new;
  entry_t            w_nxt_top;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic [PTR_W-1:0]  w_head_up;
  logic [PTR_W-1:0]  w_head_dn;
  logic [ITER_W-1:0] w_iter_inc;
  logic              w_cmp_in;
  logic              w_cmp_match;
  logic              w_nonempty;
  logic              w_in_top;
  logic              w_back;
  logic              w_pop_c;
  logic              w_clr;
  logic              w_freeze;
  logic              w_unfreeze;
  logic              w_force0;
  logic              w_active;
  logic              w_inc;
  logic              w_replace;
  logic              w_push;
  logic              w_pop;
  logic              w_nxt_in;
  logic              w_armed;

  assign w_top      = r_ring[r_head];
  assign w_head_up  = PTR_W'(ptr_wrap(32'(r_head), PTR_UP, ENTRIES));
  assign w_head_dn  = PTR_W'(ptr_wrap(32'(r_head), PTR_DN, ENTRIES));
  assign w_iter_inc = (w_top.iter == '1) ? w_top.iter : w_top.iter + 1'b1;
  assign w_new      = '{first: dec_takenbr_target, last: last_pc, iter: ITER_W'(1)};

  loop_range_cmp #(
    .PC_W (PC_W)
  ) u_top_cmp (
    .pc         (last_pc),
    .tgt        (dec_takenbr_target),
    .first      (w_top.first),
    .last       (w_top.last),
    .in_range   (w_cmp_in),
    .match_pair (w_cmp_match)
  );

  // Decode the per-cycle stack operation; earlier rules mask later ones.
  always_comb begin
    w_nonempty = (r_count != '0);
    w_in_top   = w_nonempty & w_cmp_in;
    w_back     = dec_takenbr & (dec_takenbr_target < last_pc) & ~is_call & ~r_frozen;
    w_pop_c    = inst_valid & w_nonempty & ~w_in_top & ~r_frozen;
    w_clr      = lock_clr | (is_call & (CALL_CLEAR == CALL_POLICY_CLEAR));
    w_freeze   = ~w_clr & is_call & (CALL_CLEAR == CALL_POLICY_FREEZE);
    w_unfreeze = ~w_clr & ~w_freeze & r_frozen & is_ret;
    w_force0   = w_clr | w_freeze | r_frozen;
    w_active   = ~w_force0;
    w_inc      = w_active & w_back & w_nonempty & w_cmp_match;
    w_replace  = w_active & ~w_inc & w_back & w_pop_c;
    w_push     = w_active & ~w_inc & ~w_replace & w_back;
    w_pop      = w_active & ~w_back & w_pop_c;
  end

  // Look-ahead of the top entry and count after this cycle's update, so the
  // lock reacts in the same cycle the stack changes.
  always_comb begin
    w_nxt_top = w_top;
    w_nxt_cnt = r_count;
    if (w_clr) begin
      w_nxt_cnt = '0;
    end else if (w_inc) begin
      w_nxt_top.iter = w_iter_inc;
    end else if (w_replace) begin
      w_nxt_top = w_new;
    end else if (w_push) begin
      w_nxt_top = w_new;
      w_nxt_cnt = (r_count == FULL) ? r_count : r_count + 1'b1;
    end else if (w_pop) begin
      w_nxt_top = r_ring[w_head_dn];
      w_nxt_cnt = r_count - 1'b1;
    end
    w_nxt_in   = (w_nxt_cnt != '0) && (w_nxt_top.first <= last_pc) && (last_pc <= w_nxt_top.last);
    w_armed    = (w_nxt_cnt != '0) && (w_nxt_top.iter >= THR);
    lock_cache = w_active & w_armed & (inst_valid ? w_nxt_in : r_last_lock);
    lock_start = w_active & ((w_inc & (w_iter_inc == THR) & (w_top.iter != THR)) |
                             ((w_replace | w_push) & (LOCK_THRESH == 1)));
  end

  assign depth = r_count;

  // Stack, freeze flag and previous-lock state; a full push overwrites the
  // oldest slot, which is the one just past the head.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_ring[i] <= '0;
      end
      r_head      <= '0;
      r_count     <= '0;
      r_frozen    <= 1'b0;
      r_last_lock <= 1'b0;
    end else begin
      r_last_lock <= lock_cache;
      if (w_clr) begin
        r_count  <= '0;
        r_frozen <= 1'b0;
      end else if (w_freeze) begin
        r_frozen <= 1'b1;
      end else if (w_unfreeze) begin
        r_frozen <= 1'b0;
      end else if (w_inc) begin
        r_ring[r_head].iter <= w_iter_inc;
      end else if (w_replace) begin
        r_ring[r_head] <= w_new;
      end else if (w_push) begin
        r_head            <= w_head_up;
        r_ring[w_head_up] <= w_new;
        if (r_count != FULL) begin
          r_count <= r_count + 1'b1;
        end
      end else if (w_pop) begin
        r_head  <= w_head_dn;
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_loop_lock_tracker.sv
// Bench for loop_lock_tracker: two instances (freeze policy with 3 entries,
// clear policy with 4 entries) share the stimulus and are compared each
// cycle against a list-based stack model.
module tb_loop_lock_tracker;

  localparam int THR = 2;
  localparam int IMAX = 15;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        iv, call, ret, tb, clr;
  logic [31:1] tgt, pc;

  logic        lock_a, start_a, lock_b, start_b;
  logic [1:0]  depth_a;
  logic [2:0]  depth_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model state per instance: index 0 oldest, md-1 innermost
  logic [31:1] mf [2][8];
  logic [31:1] ml [2][8];
  int          mi [2][8];
  int          md [2];
  logic        mfz [2];
  logic        mll [2];
  int          me [2];
  logic        mcc [2];

  always #5 clk = ~clk;

  loop_lock_tracker #(
    .ENTRIES     (3),
    .PC_W        (31),
    .ITER_W      (4),
    .LOCK_THRESH (2),
    .CALL_CLEAR  (0)
  ) dut_a (
    .clk                (clk),
    .rst_l              (rst_l),
    .inst_valid         (iv),
    .is_call            (call),
    .is_ret             (ret),
    .dec_takenbr        (tb),
    .dec_takenbr_target (tgt),
    .last_pc            (pc),
    .lock_clr           (clr),
    .lock_cache         (lock_a),
    .lock_start         (start_a),
    .depth              (depth_a)
  );

  loop_lock_tracker #(
    .ENTRIES     (4),
    .PC_W        (31),
    .ITER_W      (4),
    .LOCK_THRESH (2),
    .CALL_CLEAR  (1)
  ) dut_b (
    .clk                (clk),
    .rst_l              (rst_l),
    .inst_valid         (iv),
    .is_call            (call),
    .is_ret             (ret),
    .dec_takenbr        (tb),
    .dec_takenbr_target (tgt),
    .last_pc            (pc),
    .lock_clr           (clr),
    .lock_cache         (lock_b),
    .lock_start         (start_b),
    .depth              (depth_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md[k]  = 0;
      mfz[k] = 1'b0;
      mll[k] = 1'b0;
    end
  endtask

  // Applies one cycle of the stack rules to instance k; returns the expected
  // combinational outputs and the depth visible before the update.
  task automatic model_step(input int k, output logic el, output logic es, output int ed);
    logic back, ne, intop, pop, forced, armed, intop2;
    int   t, old;
    ed     = md[k];
    ne     = md[k] > 0;
    t      = ne ? md[k] - 1 : 0;
    intop  = ne && (mf[k][t] <= pc) && (pc <= ml[k][t]);
    back   = tb && (tgt < pc) && !call && !mfz[k];
    pop    = iv && ne && !intop && !mfz[k];
    forced = mfz[k];
    es     = 1'b0;
    if (clr || (call && mcc[k])) begin
      md[k]  = 0;
      mfz[k] = 1'b0;
      forced = 1'b1;
    end else if (call) begin
      mfz[k] = 1'b1;
      forced = 1'b1;
    end else if (mfz[k]) begin
      if (ret) mfz[k] = 1'b0;
    end else if (back && ne && tgt == mf[k][t] && pc == ml[k][t]) begin
      old = mi[k][t];
      if (mi[k][t] < IMAX) mi[k][t] = mi[k][t] + 1;
      es = (mi[k][t] == THR) && (old != THR);
    end else if (back && pop) begin
      mf[k][t] = tgt;
      ml[k][t] = pc;
      mi[k][t] = 1;
      es = (THR == 1);
    end else if (back) begin
      if (md[k] == me[k]) begin
        for (int j = 0; j < me[k] - 1; j++) begin
          mf[k][j] = mf[k][j+1];
          ml[k][j] = ml[k][j+1];
          mi[k][j] = mi[k][j+1];
        end
        md[k] = md[k] - 1;
      end
      mf[k][md[k]] = tgt;
      ml[k][md[k]] = pc;
      mi[k][md[k]] = 1;
      md[k] = md[k] + 1;
      es = (THR == 1);
    end else if (pop) begin
      md[k] = md[k] - 1;
    end
    t      = (md[k] > 0) ? md[k] - 1 : 0;
    armed  = (md[k] > 0) && (mi[k][t] >= THR);
    intop2 = (md[k] > 0) && (mf[k][t] <= pc) && (pc <= ml[k][t]);
    el     = !forced && armed && (iv ? intop2 : mll[k]);
    if (forced) es = 1'b0;
    mll[k] = el;
  endtask

  task automatic step(input logic v, input logic c, input logic r, input logic b,
                      input logic l, input logic [31:1] t, input logic [31:1] p);
    logic el, es;
    int   ed;
    iv = v; call = c; ret = r; tb = b; clr = l; tgt = t; pc = p;
    @(negedge clk);
    model_step(0, el, es, ed);
    check("A.lock_cache", 32'(lock_a), 32'(el));
    check("A.lock_start", 32'(start_a), 32'(es));
    check("A.depth", 32'(depth_a), 32'(ed));
    model_step(1, el, es, ed);
    check("B.lock_cache", 32'(lock_b), 32'(el));
    check("B.lock_start", 32'(start_b), 32'(es));
    check("B.depth", 32'(depth_b), 32'(ed));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // one pass of the 0x80..0x100 loop: closing branch then a body instruction
  task automatic loop_pass();
    step(1, 0, 0, 1, 0, 31'h80, 31'h100);
    step(1, 0, 0, 0, 0, 31'h0, 31'h90);
  endtask

  initial begin
    logic [31:1] tgts [4];
    logic [31:1] pcs [6];
    me[0] = 3; mcc[0] = 1'b0;
    me[1] = 4; mcc[1] = 1'b1;
    tgts = '{31'h80, 31'ha0, 31'hc0, 31'h120};
    pcs  = '{31'h90, 31'hb0, 31'hd0, 31'h100, 31'h110, 31'h130};
    model_reset();
    rst_l = 1'b0;
    iv = 0; call = 0; ret = 0; tb = 0; clr = 0; tgt = '0; pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.A.lock", 32'(lock_a), 32'd0);
    check("reset.A.start", 32'(start_a), 32'd0);
    check("reset.A.depth", 32'(depth_a), 32'd0);
    check("reset.B.lock", 32'(lock_b), 32'd0);
    check("reset.B.depth", 32'(depth_b), 32'd0);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // T1 single loop locks on the second closing branch; T2 exit pops it
    loop_pass();
    loop_pass();
    loop_pass();
    check("T1.A.depth", 32'(depth_a), 32'd1);
    step(1, 0, 0, 0, 0, 31'h0, 31'h104);
    check("T2.A.depth", 32'(depth_a), 32'd0);

    // T3 four nested loops, then exit outward
    step(1, 0, 0, 1, 0, 31'h100, 31'h400);
    step(1, 0, 0, 1, 0, 31'h180, 31'h380);
    step(1, 0, 0, 1, 0, 31'h200, 31'h300);
    step(1, 0, 0, 1, 0, 31'h240, 31'h280);
    check("T3.A.depth_sat", 32'(depth_a), 32'd3);
    check("T3.B.depth_full", 32'(depth_b), 32'd4);
    repeat (3) step(1, 0, 0, 0, 0, 31'h0, 31'h3f0);
    check("T3.A.depth_empty", 32'(depth_a), 32'd0);
    step(1, 0, 0, 0, 0, 31'h0, 31'h500);

    // T4 call inside a locked loop, callee body, return, resume in loop
    loop_pass();
    loop_pass();
    step(1, 1, 0, 1, 0, 31'h1000, 31'h94);
    step(1, 0, 0, 0, 0, 31'h0, 31'h1000);
    step(1, 0, 0, 1, 0, 31'h1000, 31'h1008);
    step(1, 0, 1, 0, 0, 31'h0, 31'h1010);
    step(1, 0, 0, 0, 0, 31'h0, 31'h94);
    step(1, 0, 0, 0, 0, 31'h0, 31'h200);

    // T5 decode bubbles after a taken branch, without and with lock_clr
    loop_pass();
    loop_pass();
    step(1, 0, 0, 1, 0, 31'h80, 31'h100);
    step(0, 0, 0, 0, 0, 31'h0, 31'h0);
    step(0, 0, 0, 0, 0, 31'h0, 31'h0);
    step(1, 0, 0, 0, 0, 31'h0, 31'h80);
    step(1, 0, 0, 1, 0, 31'h80, 31'h100);
    step(0, 0, 0, 0, 1, 31'h0, 31'h0);
    step(0, 0, 0, 0, 0, 31'h0, 31'h0);

    // T6 iteration counter saturation, then asynchronous reset mid-loop
    repeat (20) loop_pass();
    #2;
    rst_l = 1'b0;
    #1;
    check("T6.A.lock_async", 32'(lock_a), 32'd0);
    check("T6.A.depth_async", 32'(depth_a), 32'd0);
    check("T6.B.lock_async", 32'(lock_b), 32'd0);
    check("T6.B.start_async", 32'(start_b), 32'd0);
    check("T6.B.depth_async", 32'(depth_b), 32'd0);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;

    // randomized traffic around a few overlapping loops
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 4) != 0,
           ($urandom % 16) == 0,
           ($urandom % 6) == 0,
           ($urandom % 3) == 0,
           ($urandom % 40) == 0,
           tgts[$urandom_range(0, 3)],
           pcs[$urandom_range(0, 5)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
